// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - control unit <-> datapath signal bundle
interface multicycle_control_unit_if #(
  parameter int CNT_W = 16
);
  logic [6:0]       OP_Code;
  logic             Zero;
  logic             mem_ready;
  logic             PCWrite;
  logic             IRWrite;
  logic             MemRead;
  logic             MemWrite;
  logic             RegWrite;
  logic             ALUScr;
  logic             Branch;
  logic             Jump;
  logic [1:0]       ALUOp;
  logic [1:0]       MemtoReg;
  logic             Illegal;
  logic             Bus_Err;
  logic [CNT_W-1:0] Retired;

  modport master (
    input  OP_Code, Zero, mem_ready,
    output PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUScr, Branch, Jump,
           ALUOp, MemtoReg, Illegal, Bus_Err, Retired
  );

  modport slave (
    output OP_Code, Zero, mem_ready,
    input  PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUScr, Branch, Jump,
           ALUOp, MemtoReg, Illegal, Bus_Err, Retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multicycle RV-style control FSM with memory timeout traps
// Optional MCU_JALR_EN makes opcode 1100111 (JALR) a legal instruction.
module multicycle_control_unit #(
  parameter int TO_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [2:0] {C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR} cls_t;

  // Timeout fires when the counter would step onto its all-ones value.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t           state;
  cls_t             cls;
  cls_t             dec_cls;
  logic             dec_legal;
  logic [TO_W-1:0]  to_cnt;
  logic [CNT_W-1:0] retired;
  logic             illegal;
  logic             bus_err;
  logic             timed_out;

  always_comb begin
    dec_cls   = C_R;
    dec_legal = 1'b1;
    case (bus.OP_Code)
      7'b0110011: dec_cls = C_R;
      7'b0010011: dec_cls = C_I;
      7'b0000011: dec_cls = C_LOAD;
      7'b0100011: dec_cls = C_STORE;
      7'b1100011: dec_cls = C_BRANCH;
      7'b1101111: dec_cls = C_JAL;
`ifdef MCU_JALR_EN
      7'b1100111: dec_cls = C_JALR;
`endif
      default:    dec_legal = 1'b0;
    endcase
  end

  assign timed_out = !bus.mem_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH;
      cls     <= C_R;
      to_cnt  <= '0;
      retired <= '0;
      illegal <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (bus.mem_ready) begin
            state <= DECODE;
          end else if (timed_out) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DECODE: begin
          cls <= dec_cls;
          if (dec_legal) begin
            state <= EXEC;
          end else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          case (cls)
            C_R, C_I: state <= WB;
            C_LOAD, C_STORE: begin
              state  <= MEM;
              to_cnt <= '0;
            end
            default: begin
              state   <= FETCH;
              to_cnt  <= '0;
              retired <= retired + 1'b1;
            end
          endcase
        end
        MEM: begin
          if (bus.mem_ready) begin
            if (cls == C_LOAD) begin
              state <= WB;
            end else begin
              state   <= FETCH;
              to_cnt  <= '0;
              retired <= retired + 1'b1;
            end
          end else if (timed_out) begin
            state   <= TRAP;
            bus_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        WB: begin
          state   <= FETCH;
          to_cnt  <= '0;
          retired <= retired + 1'b1;
        end
        default: state <= TRAP;
      endcase
    end
  end

  always_comb begin
    bus.PCWrite  = 1'b0;
    bus.IRWrite  = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUScr   = 1'b0;
    bus.Branch   = 1'b0;
    bus.Jump     = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.MemtoReg = 2'b00;
    case (state)
      FETCH: begin
        bus.MemRead = 1'b1;
        bus.IRWrite = bus.mem_ready;
        bus.PCWrite = bus.mem_ready;
      end
      EXEC: begin
        case (cls)
          C_R: bus.ALUOp = 2'b01;
          C_I, C_LOAD, C_STORE: bus.ALUScr = 1'b1;
          C_BRANCH: begin
            bus.ALUOp   = 2'b10;
            bus.Branch  = 1'b1;
            bus.PCWrite = bus.Zero;
          end
          C_JAL: begin
            bus.Jump     = 1'b1;
            bus.PCWrite  = 1'b1;
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 2'b10;
          end
`ifdef MCU_JALR_EN
          C_JALR: begin
            bus.ALUScr   = 1'b1;
            bus.Jump     = 1'b1;
            bus.PCWrite  = 1'b1;
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 2'b10;
          end
`endif
          default: ;
        endcase
      end
      MEM: begin
        bus.MemRead  = (cls == C_LOAD);
        bus.MemWrite = (cls == C_STORE);
      end
      WB: begin
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (cls == C_LOAD) ? 2'b01 : 2'b00;
      end
      default: ;
    endcase
  end

  assign bus.Illegal = illegal;
  assign bus.Bus_Err = bus_err;
  assign bus.Retired = retired;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - scoreboard bench for multicycle_control_unit
module tb_multicycle_control_unit;
  // Control word bit order: PCWrite IRWrite MemRead MemWrite RegWrite ALUScr Branch Jump ALUOp[1:0] MemtoReg[1:0]
  localparam logic [11:0] IDLE    = 12'b0000_0000_0000;
  localparam logic [11:0] F_WAIT  = 12'b0010_0000_0000;
  localparam logic [11:0] F_DONE  = 12'b1110_0000_0000;
  localparam logic [11:0] EX_R    = 12'b0000_0000_0100;
  localparam logic [11:0] EX_I    = 12'b0000_0100_0000;
  localparam logic [11:0] EX_BRZ  = 12'b1000_0010_1000;
  localparam logic [11:0] EX_BRN  = 12'b0000_0010_1000;
  localparam logic [11:0] EX_JAL  = 12'b1000_1001_0010;
  localparam logic [11:0] MEM_LD  = 12'b0010_0000_0000;
  localparam logic [11:0] MEM_ST  = 12'b0001_0000_0000;
  localparam logic [11:0] WB_ALU  = 12'b0000_1000_0000;
  localparam logic [11:0] WB_LD   = 12'b0000_1000_0001;
`ifdef MCU_JALR_EN
  localparam logic [11:0] EX_JALR = 12'b1000_1101_0010;
`endif

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_JL = 7'b1101111;
  localparam logic [6:0] OP_JR = 7'b1100111;

  typedef struct {
    string       name;
    logic [29:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  multicycle_control_unit_if #(.CNT_W(16)) bus ();

  multicycle_control_unit #(.TO_W(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t        e;
    logic [29:0] act;
    if (sb.size() != 0) begin
      e   = sb.pop_front();
      act = {bus.PCWrite, bus.IRWrite, bus.MemRead, bus.MemWrite, bus.RegWrite, bus.ALUScr,
             bus.Branch, bus.Jump, bus.ALUOp, bus.MemtoReg, bus.Illegal, bus.Bus_Err, bus.Retired};
      n_checks++;
      if (act !== e.v) begin
        n_errors++;
        $display("FAIL %s: got ctl=%b ill/berr=%b ret=%0d, expected ctl=%b ill/berr=%b ret=%0d",
                 e.name, act[29:18], act[17:16], act[15:0], e.v[29:18], e.v[17:16], e.v[15:0]);
      end
    end
  end

  task automatic cy(input string nm, input logic [6:0] op, input logic mr, input logic z,
                    input logic [11:0] ctl, input logic [1:0] flg, input logic [15:0] ret);
    exp_t e;
    bus.OP_Code   = op;
    bus.mem_ready = mr;
    bus.Zero      = z;
    e.name = nm;
    e.v    = {ctl, flg, ret};
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.OP_Code   = 7'd0;
    bus.mem_ready = 1'b0;
    bus.Zero      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cy("reset_fetch", OP_R, 1'b0, 1'b0, F_WAIT, 2'b00, 16'd0);
    rst = 1'b0;

    // R-type, no waits; mem_ready high outside FETCH/MEM must be ignored
    cy("r_fetch",  OP_R, 1'b1, 1'b0, F_DONE, 2'b00, 16'd0);
    cy("r_decode", OP_R, 1'b1, 1'b0, IDLE,   2'b00, 16'd0);
    cy("r_exec",   OP_R, 1'b1, 1'b0, EX_R,   2'b00, 16'd0);
    cy("r_wb",     OP_R, 1'b1, 1'b0, WB_ALU, 2'b00, 16'd0);

    // LOAD with three MEM wait cycles
    cy("ld_fetch",  OP_LD, 1'b1, 1'b0, F_DONE, 2'b00, 16'd1);
    cy("ld_decode", OP_LD, 1'b0, 1'b0, IDLE,   2'b00, 16'd1);
    cy("ld_exec",   OP_LD, 1'b1, 1'b0, EX_I,   2'b00, 16'd1);
    for (int i = 0; i < 3; i++) cy("ld_mem_wait", OP_LD, 1'b0, 1'b0, MEM_LD, 2'b00, 16'd1);
    cy("ld_mem_done", OP_LD, 1'b1, 1'b0, MEM_LD, 2'b00, 16'd1);
    cy("ld_wb",       OP_LD, 1'b1, 1'b0, WB_LD,  2'b00, 16'd1);

    cy("st_fetch",  OP_ST, 1'b1, 1'b0, F_DONE, 2'b00, 16'd2);
    cy("st_decode", OP_ST, 1'b1, 1'b0, IDLE,   2'b00, 16'd2);
    cy("st_exec",   OP_ST, 1'b1, 1'b0, EX_I,   2'b00, 16'd2);
    cy("st_mem",    OP_ST, 1'b1, 1'b0, MEM_ST, 2'b00, 16'd2);

    cy("i_fetch",  OP_I, 1'b1, 1'b0, F_DONE, 2'b00, 16'd3);
    cy("i_decode", OP_I, 1'b1, 1'b1, IDLE,   2'b00, 16'd3);
    cy("i_exec",   OP_I, 1'b1, 1'b1, EX_I,   2'b00, 16'd3);
    cy("i_wb",     OP_I, 1'b1, 1'b1, WB_ALU, 2'b00, 16'd3);

    cy("brz_fetch",  OP_BR, 1'b1, 1'b1, F_DONE, 2'b00, 16'd4);
    cy("brz_decode", OP_BR, 1'b1, 1'b1, IDLE,   2'b00, 16'd4);
    cy("brz_exec",   OP_BR, 1'b1, 1'b1, EX_BRZ, 2'b00, 16'd4);
    cy("brn_fetch",  OP_BR, 1'b1, 1'b0, F_DONE, 2'b00, 16'd5);
    cy("brn_decode", OP_BR, 1'b1, 1'b0, IDLE,   2'b00, 16'd5);
    cy("brn_exec",   OP_BR, 1'b1, 1'b0, EX_BRN, 2'b00, 16'd5);

    cy("jal_fetch",  OP_JL, 1'b1, 1'b0, F_DONE, 2'b00, 16'd6);
    cy("jal_decode", OP_JL, 1'b1, 1'b0, IDLE,   2'b00, 16'd6);
    cy("jal_exec",   OP_JL, 1'b1, 1'b0, EX_JAL, 2'b00, 16'd6);

    // Fetch completes on the 15th cycle, exactly at the timeout limit
    for (int i = 0; i < 14; i++) cy("fetch_wait14", OP_R, 1'b0, 1'b0, F_WAIT, 2'b00, 16'd7);
    cy("fetch_done_at_limit", OP_R, 1'b1, 1'b0, F_DONE, 2'b00, 16'd7);
    cy("late_decode", OP_R, 1'b0, 1'b0, IDLE,   2'b00, 16'd7);
    cy("late_exec",   OP_R, 1'b0, 1'b0, EX_R,   2'b00, 16'd7);
    cy("late_wb",     OP_R, 1'b0, 1'b0, WB_ALU, 2'b00, 16'd7);

    cy("jalr_fetch",  OP_JR, 1'b1, 1'b0, F_DONE, 2'b00, 16'd8);
    cy("jalr_decode", OP_JR, 1'b1, 1'b0, IDLE,   2'b00, 16'd8);
`ifdef MCU_JALR_EN
    cy("jalr_exec",   OP_JR, 1'b1, 1'b0, EX_JALR, 2'b00, 16'd8);
    cy("bad_fetch",   7'h7F, 1'b1, 1'b0, F_DONE,  2'b00, 16'd9);
    cy("bad_decode",  7'h7F, 1'b1, 1'b0, IDLE,    2'b00, 16'd9);
    for (int i = 0; i < 3; i++) cy("illegal_trap", 7'h7F, i[0], 1'b1, IDLE, 2'b10, 16'd9);
    rst = 1'b1;
    cy("trap_under_rst", 7'h7F, 1'b1, 1'b0, IDLE, 2'b10, 16'd9);
`else
    for (int i = 0; i < 3; i++) cy("jalr_illegal_trap", OP_JR, i[0], 1'b1, IDLE, 2'b10, 16'd8);
    rst = 1'b1;
    cy("trap_under_rst", OP_JR, 1'b1, 1'b0, IDLE, 2'b10, 16'd8);
`endif
    rst = 1'b0;

    // Fetch never completes: bus error trap after 15 waiting cycles
    for (int i = 0; i < 15; i++) cy("fetch_timeout_wait", OP_R, 1'b0, 1'b0, F_WAIT, 2'b00, 16'd0);
    cy("bus_err_trap",      OP_R, 1'b0, 1'b0, IDLE, 2'b01, 16'd0);
    cy("bus_err_trap_hold", OP_R, 1'b1, 1'b0, IDLE, 2'b01, 16'd0);
    rst = 1'b1;
    cy("bus_err_under_rst", OP_R, 1'b0, 1'b0, IDLE, 2'b01, 16'd0);
    rst = 1'b0;
    cy("post_trap_fetch", OP_R, 1'b0, 1'b0, F_WAIT, 2'b00, 16'd0);

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameters SHALL be: TO_W, 4, memory-wait timeout counter width; CNT_W, 16, retired-instruction counter width.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 OP_Code  input  7  opcode field of the instruction register; valid from DECODE onward.
REQ-005 Zero  input  1  ALU zero flag; sampled in EXEC.
REQ-006 mem_ready  input  1  memory completion handshake for the current fetch or data access.
REQ-007 PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUScr, Branch, Jump  output  1 each  datapath enables.
REQ-008 ALUOp, MemtoReg  output  2 each  ALU class (01 R-type, 00 add, 10 compare); writeback select (00 ALU, 01 memory, 10 PC+4).
REQ-009 Illegal, Bus_Err  output  1 each  sticky trap causes.
REQ-010 Retired  output  CNT_W  count of completed instructions.

Function
REQ-011 The block SHALL be a Moore FSM with states FETCH, DECODE, EXEC, MEM, WB, TRAP; outputs SHALL depend only on state, latched opcode class, Zero (EXEC only) and mem_ready (FETCH/MEM only).
REQ-012 Every output not listed active for a state SHALL be driven 0; no output SHALL ever be X.
REQ-013 FETCH: MemRead=1; on mem_ready=1, IRWrite=1 and PCWrite=1 in that cycle and next state DECODE; otherwise remain.
REQ-014 DECODE: opcode class SHALL be latched from OP_Code; classes R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111 go to EXEC; any other opcode goes to TRAP with Illegal set.
REQ-015 EXEC: R drives ALUOp=01, ALUScr=0, then WB; I drives ALUOp=00, ALUScr=1, then WB; LOAD/STORE drive ALUOp=00, ALUScr=1, then MEM.
REQ-016 EXEC BRANCH: ALUOp=10, ALUScr=0, Branch=1, PCWrite=Zero, then FETCH; instruction retires.
REQ-017 EXEC JAL: Jump=1, PCWrite=1, RegWrite=1, MemtoReg=10, then FETCH; instruction retires.
REQ-018 MEM: LOAD holds MemRead=1, STORE holds MemWrite=1, until mem_ready=1; LOAD then goes to WB, STORE then goes to FETCH and retires.
REQ-019 WB: RegWrite=1, MemtoReg=01 for LOAD else 00, then FETCH; instruction retires.
REQ-020 Latency: R/I 4 cycles, LOAD 5, STORE 4, BRANCH/JAL 3, each with zero memory wait; each wait cycle adds one.
REQ-021 A timeout counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0 there; reaching 2^TO_W-1 with mem_ready=0 SHALL enter TRAP with Bus_Err=1.
REQ-022 mem_ready=1 in the same cycle the counter reaches its limit SHALL count as completion, not timeout.
REQ-023 TRAP SHALL hold all enables 0 and stay until rst.
REQ-024 Retired SHALL increment by 1 on the cycle of the final state transition of each instruction and wrap from 2^CNT_W-1 to 0.
REQ-025 mem_ready outside FETCH/MEM SHALL be ignored.

Reset
REQ-026 On rst=1 at a clock edge, state SHALL become FETCH, timeout counter, Retired, Illegal and Bus_Err SHALL become 0, regardless of current state, including mid-wait or TRAP.
REQ-027 During the first cycle after reset, outputs SHALL be the FETCH values: MemRead=1, all others 0.

Configuration
REQ-028 Macro MCU_JALR_EN: when defined, opcode 1100111 SHALL be legal; EXEC drives ALUOp=00, ALUScr=1, Jump=1, PCWrite=1, RegWrite=1, MemtoReg=10, then FETCH, retiring in 3 cycles; when undefined, 1100111 SHALL go to TRAP with Illegal=1.

Verification
REQ-029 Reset, then R-type 0110011 with mem_ready always 1 -> states FETCH,DECODE,EXEC,WB; RegWrite=1 only in cycle 4; Retired=1.
REQ-030 LOAD with mem_ready low 3 cycles in MEM -> MemRead held 4 MEM cycles, WB MemtoReg=01, total 8 cycles.
REQ-031 BRANCH with Zero=1 then Zero=0 -> PCWrite=1 in first EXEC only; Retired=2.
REQ-032 TO_W=4, mem_ready held 0 in FETCH -> TRAP after 15 cycles, Bus_Err=1; mem_ready=1 on cycle 15 instead -> DECODE, no error.
REQ-033 Opcode 1100111 with and without MCU_JALR_EN -> JALR retires in 3 cycles / Illegal=1 and TRAP; rst=1 from TRAP -> FETCH, flags 0.
